// File: rtl/bcd_divisibility_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_divisibility_ctrl_if
// Purpose  : Input-word and result handshake bundle for bcd_divisibility_ctrl.
//            The slave modport is the checker's view; master is the producer
//            and consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_divisibility_ctrl_if #(
  parameter int NDIG = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              div3;
  logic              div11;
  logic [1:0]        rem3;
  logic [3:0]        rem11;
  logic              err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, div3, div11, rem3, rem11, err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, div3, div11, rem3, rem11, err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_divisibility_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_divisibility_ctrl
// Purpose  : Sequential divisibility-by-3 and -by-11 checker for packed BCD
//            words. One digit per clock, MSD first, using running residues
//            (10 = 1 mod 3, 10 = -1 mod 11). Flags non-BCD digits.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_divisibility_ctrl #(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_divisibility_ctrl_if.slave  bus
);
  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] C_LAST_CNT = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     r3_q, r3_d;
  logic [3:0]     r11_q, r11_d;
  logic           acc_err_q, acc_err_d;
  logic [1:0]     rem3_q, rem3_d;
  logic [3:0]     rem11_q, rem11_d;
  logic           err_q, err_d;
  logic           div3_q, div3_d;
  logic           div11_q, div11_d;

  logic [3:0]     w_dig;
  logic [4:0]     w_sum3;
  logic [4:0]     w_mod3;
  logic [5:0]     w_diff;
  logic [5:0]     w_adj;
  logic [1:0]     w_r3_next;
  logic [3:0]     w_r11_next;
  logic           w_bad_dig;

  assign w_dig = sreg_q[W-1 -: 4];

  // Residue step for the digit at the top of the shift register; invalid
  // digits are reduced as plain 4-bit values so residues stay in range.
  always_comb begin
    w_sum3 = {3'b000, r3_q} + {1'b0, w_dig};
    w_mod3 = w_sum3 % 5'd3;
    w_diff = {2'b00, w_dig} - {2'b00, r11_q};
    if (w_diff[5]) begin
      w_adj = w_diff + 6'd11;
    end else if (w_diff >= 6'd11) begin
      w_adj = w_diff - 6'd11;
    end else begin
      w_adj = w_diff;
    end
    w_r3_next  = w_mod3[1:0];
    w_r11_next = w_adj[3:0];
    w_bad_dig  = (w_dig > 4'd9);
  end

  // Next-state and datapath update; everything holds by default.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    r3_d      = r3_q;
    r11_d     = r11_q;
    acc_err_d = acc_err_q;
    rem3_d    = rem3_q;
    rem11_d   = rem11_q;
    err_d     = err_q;
    div3_d    = div3_q;
    div11_d   = div11_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sreg_d    = bus.in_data;
          r3_d      = 2'd0;
          r11_d     = 4'd0;
          acc_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sreg_d    = sreg_q << 4;
        r3_d      = w_r3_next;
        r11_d     = w_r11_next;
        acc_err_d = acc_err_q | w_bad_dig;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == C_LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
          rem3_d  = w_r3_next;
          rem11_d = w_r11_next;
          err_d   = acc_err_d;
          div3_d  = (w_r3_next == 2'd0) & ~acc_err_d;
          div11_d = (w_r11_next == 4'd0) & ~acc_err_d;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      r3_q      <= 2'd0;
      r11_q     <= 4'd0;
      acc_err_q <= 1'b0;
      rem3_q    <= 2'd0;
      rem11_q   <= 4'd0;
      err_q     <= 1'b0;
      div3_q    <= 1'b0;
      div11_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      r3_q      <= r3_d;
      r11_q     <= r11_d;
      acc_err_q <= acc_err_d;
      rem3_q    <= rem3_d;
      rem11_q   <= rem11_d;
      err_q     <= err_d;
      div3_q    <= div3_d;
      div11_q   <= div11_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.rem3      = rem3_q;
  assign bus.rem11     = rem11_q;
  assign bus.err       = err_q;
  assign bus.div3      = div3_q;
  assign bus.div11     = div11_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_divisibility_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_divisibility_ctrl
// Purpose  : Directed-vector bench for bcd_divisibility_ctrl (NDIG=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_divisibility_ctrl;
  localparam int NDIG = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  bcd_divisibility_ctrl_if #(.NDIG(NDIG)) bus ();

  bcd_divisibility_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  rem3;
    logic [3:0]  rem11;
    logic        err;
    logic        div3;
    logic        div11;
    logic        chk_rem;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a word, wait for the result, check latency, then release it.
  task automatic run_word(input vec_t v, input bit release_it);
    int lat;
    int guard;
    bus.in_data  = v.data;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("in_ready_before_accept", 16'(bus.in_ready), 16'd1);
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 16'(lat), 16'(NDIG));
    chk("err", 16'(bus.err), 16'(v.err));
    chk("div3", 16'(bus.div3), 16'(v.div3));
    chk("div11", 16'(bus.div11), 16'(v.div11));
    if (v.chk_rem) begin
      chk("rem3", 16'(bus.rem3), 16'(v.rem3));
      chk("rem11", 16'(bus.rem11), 16'(v.rem11));
    end else begin
      chk("rem3_range", 16'(bus.rem3 < 2'd3), 16'd1);
      chk("rem11_range", 16'(bus.rem11 < 4'd11), 16'd1);
    end
    if (release_it) begin
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("out_valid_after_release", 16'(bus.out_valid), 16'd0);
      chk("in_ready_after_release", 16'(bus.in_ready), 16'd1);
    end
  endtask

  initial begin
    logic [1:0] h_rem3;
    logic [3:0] h_rem11;
    logic       h_div3;
    logic       h_div11;
    logic       h_err;
    int         lat;
    vec_t       v;

    n_chk  = 0;
    n_fail = 0;
    //            data      r3    r11    err   d3    d11   chk_rem
    vecs[0]  = '{16'h1234, 2'd1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{16'h9999, 2'd0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{16'h0000, 2'd0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{16'h1A34, 2'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h0121, 2'd1, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{16'h0033, 2'd0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{16'h1000, 2'd1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'h0007, 2'd1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{16'h9876, 2'd0, 4'd9,  1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'hFFFF, 2'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h0010, 2'd1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{16'h0099, 2'd0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_div3", 16'(bus.div3), 16'd0);
    chk("rst_div11", 16'(bus.div11), 16'd0);
    chk("rst_rem3", 16'(bus.rem3), 16'd0);
    chk("rst_rem11", 16'(bus.rem11), 16'd0);
    chk("rst_err", 16'(bus.err), 16'd0);
    rst_n = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_word(vecs[i], 1'b1);
    end

    // Back-to-back with in_valid held high: 0121 then 0033
    run_word(vecs[4], 1'b0);
    bus.in_data  = 16'h0033;
    bus.in_valid = 1'b1;
    step();
    chk("b2b_no_accept_in_done", 16'(bus.out_valid), 16'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("b2b_in_ready_after_release", 16'(bus.in_ready), 16'd1);
    chk("b2b_out_valid_after_release", 16'(bus.out_valid), 16'd0);
    step();
    bus.in_valid = 1'b0;
    chk("b2b_accepted", 16'(bus.in_ready), 16'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("b2b_latency", 16'(lat), 16'(NDIG));
    chk("b2b_rem3", 16'(bus.rem3), 16'd0);
    chk("b2b_div3", 16'(bus.div3), 16'd1);
    chk("b2b_div11", 16'(bus.div11), 16'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Backpressure: hold result 5 cycles while in_valid pulses
    run_word(vecs[0], 1'b0);
    h_rem3  = 2'd1;
    h_rem11 = 4'd2;
    h_div3  = 1'b0;
    h_div11 = 1'b0;
    h_err   = 1'b0;
    bus.in_data = 16'h9999;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      step();
      chk("bp_out_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
      chk("bp_rem3", 16'(bus.rem3), 16'(h_rem3));
      chk("bp_rem11", 16'(bus.rem11), 16'(h_rem11));
      chk("bp_flags", 16'({bus.div3, bus.div11, bus.err}), 16'({h_div3, h_div11, h_err}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_in_ready_after_release", 16'(bus.in_ready), 16'd1);
    chk("bp_out_valid_after_release", 16'(bus.out_valid), 16'd0);

    // Reset during the second RUN cycle
    bus.in_data  = 16'h1234;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_rem", 16'({bus.rem3, bus.rem11}), 16'd0);
    chk("mid_rst_flags", 16'({bus.div3, bus.div11, bus.err}), 16'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_no_out_valid", 16'(bus.out_valid), 16'd0);
    end
    v = '{16'h0011, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    run_word(v, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
